serial_adder_seq: RTL and testbench

- Parametrised, multi-cycle successor to the two-half-adder full-adder cell.
- Adds (or subtracts) two WIDTH-bit operands DIGIT bits per clock, with a registered carry between digits.
- Start/busy/done handshake; result registers are held until the next operation.
- Sits in the arithmetic datapath wherever a full parallel adder is too large and a few cycles of latency are acceptable.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/full_add_cell.sv | 23 ++
 rtl/serial_adder_seq.sv | 131 +++++++++++++
 tb/tb_serial_adder_seq.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath definitions.
//   state_t : serial adder FSM encoding (IDLE, RUN, DONE)
//   clog2   : ceiling log2, used to size digit counters
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2 of v; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/full_add_cell.sv
// 1-bit combinational full adder, chained DIGIT times per cycle.
//   x, y : operand bits
//   z    : carry in
//   s    : sum bit
//   c    : carry out
module full_add_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic s,
  output logic c
);

  // Two half adders plus an OR, as in the original cell.
  logic hs, hc1, hc2;

  assign hs  = x ^ y;
  assign hc1 = x & y;
  assign s   = hs ^ z;
  assign hc2 = hs & z;
  assign c   = hc1 | hc2;

endmodule

// File: rtl/serial_adder_seq.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per clock,
// N = WIDTH/DIGIT cycles per operation with a start/busy/done handshake.
//   clk, rst  : clock, synchronous active-high reset
//   start     : request an operation (honoured only in IDLE)
//   a, b      : operands, captured on the accepting edge
//   cin       : carry-in for add; ignored when sub=1
//   sub       : 1 -> a-b (a + ~b + 1), 0 -> a+b+cin
//   busy      : operation in progress
//   done      : one-cycle pulse when sum/cout/ovf update
//   sum       : result modulo 2^WIDTH, held until next completion
//   cout      : carry out of MSB (in sub mode 1 = no borrow)
//   ovf       : two's-complement overflow
module serial_adder_seq
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? clog2(N) : 1;

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
      $error("serial_adder_seq: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Per-cycle carry chain: c[0] is the registered carry, c[DIGIT] the digit carry-out.
  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] dsum;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  assign c[0] = carry;

  genvar i;
  generate
    for (i = 0; i < DIGIT; i++) begin : g_cell
      full_add_cell u_cell (
        .x (a_sr[i]),
        .y (b_sr[i]),
        .z (c[i]),
        .s (dsum[i]),
        .c (c[i+1])
      );
    end
  endgenerate

  // New digit enters at the MSB end; written as a wide shift so DIGIT == WIDTH
  // needs no special-case slice.
  always_comb begin
    sum_nxt = WIDTH'({dsum, sum_sr} >> DIGIT);
  end

  assign last = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          sum_sr <= sum_nxt;
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          carry  <= c[DIGIT];
          cnt    <= cnt + CW'(1);
          if (last) begin
            // c[DIGIT-1] is the carry into the MSB cell on the final digit.
            sum   <= sum_nxt;
            cout  <= c[DIGIT];
            ovf   <= c[DIGIT-1] ^ c[DIGIT];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench: one DUT at DIGIT=1 and one at DIGIT=4, both WIDTH=8.
module tb_serial_adder_seq;

  logic       clk = 1'b0;
  logic       rst;
  int         checks = 0;
  int         errors = 0;

  logic       start1, cin1, sub1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, sum1;
  logic       start4, cin4, sub4, busy4, done4, cout4, ovf4;
  logic [7:0] a4, b4, sum4;

  always #5 clk = ~clk;

  serial_adder_seq #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder_seq #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Full operation on dut1 with latency and busy-length checks.
  task automatic op1(input string tag, input logic [7:0] av, input logic [7:0] bv,
                     input logic ci, input logic sb, input logic [7:0] es,
                     input logic ec, input logic eo);
    int lat, bcnt;
    a1 = av; b1 = bv; cin1 = ci; sub1 = sb; start1 = 1'b1;
    cyc();
    start1 = 1'b0;
    a1 = ~av; b1 = ~bv; cin1 = ~ci; sub1 = ~sb;   // operands must already be captured
    lat = 0; bcnt = 0;
    while (!done1 && lat < 20) begin
      if (busy1) bcnt++;
      cyc();
      lat++;
    end
    chk({tag, "_lat"},  lat, 8);
    chk({tag, "_busy"}, bcnt, 8);
    chk({tag, "_sum"},  sum1, es);
    chk({tag, "_cout"}, cout1, ec);
    chk({tag, "_ovf"},  ovf1, eo);
    chk({tag, "_bsy0"}, busy1, 0);
    cyc();
    chk({tag, "_dn0"},  done1, 0);
  endtask

  initial begin
    int k, pulses, lat, reacc, rise_k;
    logic fell;
    rst = 1'b1;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0; sub1 = 0;
    start4 = 0; a4 = 0; b4 = 0; cin4 = 0; sub4 = 0;
    @(negedge clk);
    cyc();
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_sum",  sum1, 0);
    chk("rst_cout", {cout1, ovf1}, 0);
    chk("rst4_out", {busy4, done4, sum4, cout4, ovf4}, 0);
    rst = 1'b0;
    cyc();

    op1("add5a3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
    op1("sub1020", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0);
    op1("sub8001", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
    op1("addff01", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);

    // start pulses during RUN must be ignored
    a1 = 8'h5A; b1 = 8'h3C; cin1 = 0; sub1 = 0; start1 = 1;
    cyc();
    start1 = 0;
    pulses = 0; lat = -1; reacc = 0;
    for (k = 1; k <= 16; k++) begin
      start1 = (k == 2 || k == 4 || k == 6);
      a1 = 8'h01; b1 = 8'h01;
      cyc();
      if (done1) begin
        pulses++;
        if (lat < 0) lat = k;
      end
      if (lat >= 0 && k > lat && busy1) reacc++;
    end
    start1 = 0;
    chk("ign_pulses", pulses, 1);
    chk("ign_lat",    lat, 8);
    chk("ign_sum",    sum1, 8'h96);
    chk("ign_reacc",  reacc, 0);

    // reset at cycle 5 of a run abandons it
    a1 = 8'h10; b1 = 8'h20; sub1 = 1; start1 = 1;
    cyc();
    start1 = 0;
    for (k = 1; k <= 4; k++) cyc();
    rst = 1;
    cyc();
    rst = 0;
    chk("mid_rst_out", {busy1, done1, sum1, cout1, ovf1}, 0);
    pulses = 0;
    for (k = 0; k < 12; k++) begin
      cyc();
      if (done1 || busy1) pulses++;
    end
    chk("mid_rst_nodone", pulses, 0);
    op1("after_rst", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);

    // DIGIT=4: two-cycle latency
    a4 = 8'h7F; b4 = 8'h01; cin4 = 0; sub4 = 0; start4 = 1;
    cyc();
    start4 = 0;
    lat = 0;
    while (!done4 && lat < 20) begin
      cyc();
      lat++;
    end
    chk("d4_lat",  lat, 2);
    chk("d4_sum",  sum4, 8'h80);
    chk("d4_cout", cout4, 0);
    chk("d4_ovf",  ovf4, 1);

    // back-to-back with start held high: re-accept N+2 edges after first
    cyc();
    a4 = 8'h01; b4 = 8'h02; start4 = 1;
    cyc();
    fell = 0; rise_k = -1;
    for (k = 1; k <= 12 && rise_k < 0; k++) begin
      cyc();
      if (!busy4) fell = 1;
      else if (fell) rise_k = k;
    end
    start4 = 0;
    chk("b2b_spacing", rise_k, 4);
    lat = 0;
    while (!done4 && lat < 20) begin
      cyc();
      lat++;
    end
    chk("b2b_sum", sum4, 8'h03);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
